pe_loader: RTL and testbench
============================

// Module: pe_loader
// PURPOSE
//  Host-side transmitter that feeds one pe over its load interface. It accepts a
//  ready/valid word stream from the host. Instructions are forwarded to the PE's
//  instruction memory port. Data words are buffered and replayed as gap-free bursts
//  of exactly BURST beats, which the PE's DMEM write counter requires. alpha_v is
//  driven high for the final iteration so the PE emits its result on dout_pe.
// PARAMETERS
//  DATA_W     16  real/imag component width (`DATA_WIDTH); PE data word = 2*DATA_W
//  INST_W     32  instruction width (`INST_WIDTH)
//  BURST      16  data beats per burst (= `REG_NUM*2)
//  INST_DEPTH 16  maximum instructions per program
//  ALPHA_HOLD 16  cycles alpha_v stays high after the last beat of the last burst
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous active-low reset
//  start      in   1         one-cycle program/load request
//  n_inst     in   5         instruction count, 1..INST_DEPTH, sampled on start
//  n_iter     in   8         data bursts (iterations), 1..255, sampled on start
//  s_valid    in   1         host word valid
//  s_ready    out  1         host word accepted when s_valid&s_ready
//  s_type     in   1         0 = instruction word, 1 = data word
//  s_last     in   1         marks the final instruction and the final beat of each burst
//  s_data     in   2*DATA_W  host word (instructions use s_data[INST_W-1:0], zero-extended)
//  inst_in_v  out  1         to pe.inst_in_v
//  inst_in    out  INST_W    to pe.inst_in
//  din_pe_v   out  1         to pe.din_pe_v
//  din_pe     out  2*DATA_W  to pe.din_pe
//  alpha_v    out  1         to pe.alpha_v
//  busy       out  1         high whenever state != IDLE
//  done       out  1         one-cycle pulse when returning to IDLE after success
//  err        out  1         sticky protocol error; cleared by the next accepted start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters and buffer pointers 0.
//  All PE-side outputs are registered.
//  FSM: IDLE -> INST -> GAP -> COLLECT -> SEND -> (COLLECT | HOLD) -> IDLE.
//  IDLE: s_ready=0.
//   - On start, latch n_inst and n_iter, then clear err.
//   - If n_inst==0, n_inst>INST_DEPTH or n_iter==0: set err and stay IDLE.
//   - start while busy is ignored.
//  INST: s_ready=1. Each accepted beat drives inst_in_v=1 and inst_in=word on the next cycle.
//   - Beat with s_type=1: dropped, err set, count not advanced.
//   - s_last must coincide with beat n_inst. A mismatch sets err; the count still governs.
//   - After beat n_inst: go to GAP.
//  GAP: exactly one cycle with all valids low, so inst_in_v and din_pe_v are never both high.
//  COLLECT: s_ready=1 until BURST data beats are stored in the buffer (BURST x 2*DATA_W).
//   - Host stalls are allowed.
//   - s_type=0 beats are dropped and set err.
//   - s_last must be on beat BURST, otherwise err.
//   - The cycle after the BURST-th beat: go to SEND.
//  SEND: s_ready=0. din_pe_v=1 for exactly BURST consecutive cycles.
//   - din_pe carries buffered words in arrival order.
//   - din_pe_v drops for at least one cycle between bursts, resetting the PE's DMEM counter.
//   - Iteration counter increments at the end of each burst.
//   - Go to COLLECT if iterations < n_iter, else go to HOLD.
//  alpha_v: rises with the first SEND beat of burst n_iter.
//   - Stays high through that burst plus ALPHA_HOLD cycles in HOLD.
//   - Falls in the same cycle that done pulses; state returns to IDLE.
//  Latency: host beat to inst_in_v is 1 cycle. Last collected beat to first din_pe_v is 2 cycles.
//  err never aborts a load; only rst aborts.
//  Reset mid-operation: outputs clear immediately (asynchronously), state returns to IDLE,
//  and partial buffer content is discarded.
// TESTING
//  1 rst low while busy in SEND -> din_pe_v, alpha_v, s_ready, busy fall without a clock edge; after release, state is IDLE.
//  2 start n_inst=3,n_iter=1; instructions 0x00000011..13, then data 0..15 -> three inst_in_v pulses in order;
//    one idle cycle; din_pe_v high 16 cycles carrying 0..15; alpha_v 16+16 cycles; one done pulse.
//  3 s_valid toggles every other cycle during COLLECT -> din_pe_v still 16 contiguous cycles, data in order.
//  4 n_iter=2 -> two 16-beat bursts with a gap of at least 16 cycles; alpha_v low in burst 1, high from first beat of burst 2.
//  5 s_type=1 during INST, and s_last on data beat 10 -> err=1, bad beat not forwarded, load completes; next start clears err.
//  6 start with n_inst=0 -> err=1, busy stays 0, s_ready stays 0; start while busy -> no effect.

Source files
------------

// File: rtl/pe_loader.sv
// pe_loader: host-to-PE load sequencer. Forwards instructions to the PE, then replays
// buffered data words as gap-free BURST-beat bursts, raising alpha_v on the final one.
module pe_loader #(
  parameter int DATA_W     = 16,
  parameter int INST_W     = 32,
  parameter int BURST      = 16,
  parameter int INST_DEPTH = 16,
  parameter int ALPHA_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          n_inst,
  input  logic [7:0]          n_iter,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_type,
  input  logic                s_last,
  input  logic [2*DATA_W-1:0] s_data,
  output logic                inst_in_v,
  output logic [INST_W-1:0]   inst_in,
  output logic                din_pe_v,
  output logic [2*DATA_W-1:0] din_pe,
  output logic                alpha_v,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int PW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int HW = $clog2(ALPHA_HOLD + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INST    = 3'd1,
    GAP     = 3'd2,
    COLLECT = 3'd3,
    SEND    = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [4:0]          ninst_reg;
  logic [7:0]          niter_reg;
  logic [4:0]          icnt_reg;
  logic [PW-1:0]       wptr_reg;
  logic [PW-1:0]       rptr_reg;
  logic [7:0]          iter_reg;
  logic [HW-1:0]       hcnt_reg;
  logic [2*DATA_W-1:0] buf_mem [BURST];

  logic accept, cfg_bad, last_inst, last_wr, last_rd, last_iter, hold_end, wr_en;

  assign s_ready   = (state_reg == INST) || (state_reg == COLLECT);
  assign busy      = (state_reg != IDLE);
  assign accept    = s_valid && s_ready;
  assign cfg_bad   = (n_inst == 5'd0) || ({27'd0, n_inst} > 32'(INST_DEPTH)) || (n_iter == 8'd0);
  assign last_inst = (icnt_reg == ninst_reg - 5'd1);
  assign last_wr   = (wptr_reg == PW'(BURST - 1));
  assign last_rd   = (rptr_reg == PW'(BURST - 1));
  assign last_iter = (iter_reg == niter_reg - 8'd1);
  assign hold_end  = (hcnt_reg == HW'(ALPHA_HOLD));
  assign wr_en     = (state_reg == COLLECT) && accept && s_type;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start && !cfg_bad) state_next = INST;
      INST:    if (accept && !s_type && last_inst) state_next = GAP;
      GAP:     state_next = COLLECT;
      COLLECT: if (accept && s_type && last_wr) state_next = SEND;
      SEND:    if (last_rd) state_next = last_iter ? HOLD : COLLECT;
      HOLD:    if (hold_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst buffer: written only while collecting, read only while sending.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wptr_reg] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ninst_reg <= '0;
      niter_reg <= '0;
      icnt_reg  <= '0;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      iter_reg  <= '0;
      hcnt_reg  <= '0;
      inst_in_v <= 1'b0;
      inst_in   <= '0;
      din_pe_v  <= 1'b0;
      din_pe    <= '0;
      alpha_v   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      inst_in_v <= 1'b0;
      din_pe_v  <= 1'b0;
      done      <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            ninst_reg <= n_inst;
            niter_reg <= n_iter;
            err       <= cfg_bad;
            icnt_reg  <= '0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            iter_reg  <= '0;
            hcnt_reg  <= '0;
            alpha_v   <= 1'b0;
          end
        end
        INST: begin
          if (accept) begin
            if (s_type) begin
              err <= 1'b1;
            end else begin
              inst_in_v <= 1'b1;
              inst_in   <= s_data[INST_W-1:0];
              icnt_reg  <= icnt_reg + 5'd1;
              if (s_last != last_inst) err <= 1'b1;
            end
          end
        end
        GAP: ;
        COLLECT: begin
          if (accept) begin
            if (!s_type) begin
              err <= 1'b1;
            end else begin
              wptr_reg <= last_wr ? '0 : wptr_reg + PW'(1);
              if (s_last != last_wr) err <= 1'b1;
            end
          end
        end
        SEND: begin
          din_pe_v <= 1'b1;
          din_pe   <= buf_mem[rptr_reg];
          alpha_v  <= last_iter;
          rptr_reg <= last_rd ? '0 : rptr_reg + PW'(1);
          if (last_rd) iter_reg <= iter_reg + 8'd1;
        end
        HOLD: begin
          // alpha_v drops on the same edge that raises done
          if (hold_end) begin
            alpha_v <= 1'b0;
            done    <= 1'b1;
          end else begin
            alpha_v  <= 1'b1;
            hcnt_reg <= hcnt_reg + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_loader.sv
// tb_pe_loader: table-driven directed bench for pe_loader with a negedge monitor
// that records every PE-side beat, plus hand-written reset corner cases.
module tb_pe_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  n_inst = '0;
  logic [7:0]  n_iter = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_type = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic        inst_in_v;
  logic [31:0] inst_in;
  logic        din_pe_v;
  logic [31:0] din_pe;
  logic        alpha_v;
  logic        busy;
  logic        done;
  logic        err;

  pe_loader dut (
    .clk(clk), .rst(rst), .start(start), .n_inst(n_inst), .n_iter(n_iter),
    .s_valid(s_valid), .s_ready(s_ready), .s_type(s_type), .s_last(s_last), .s_data(s_data),
    .inst_in_v(inst_in_v), .inst_in(inst_in), .din_pe_v(din_pe_v), .din_pe(din_pe),
    .alpha_v(alpha_v), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: everything seen on the PE side, sampled on the falling edge
  int          cyc = 0;
  logic [31:0] inst_q[$];
  int          inst_cyc[$];
  logic [31:0] din_q[$];
  int          din_cyc[$];
  bit          din_alpha[$];
  int          runs[$];
  int          run_len = 0;
  int          alpha_cnt = 0;
  int          done_cnt = 0;
  int          done_ok = 0;
  int          overlap = 0;
  bit          prev_alpha = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inst_in_v) begin
      inst_q.push_back(inst_in);
      inst_cyc.push_back(cyc);
    end
    if (din_pe_v) begin
      din_q.push_back(din_pe);
      din_cyc.push_back(cyc);
      din_alpha.push_back(alpha_v);
      run_len++;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (alpha_v) alpha_cnt++;
    if (done) begin
      done_cnt++;
      if (!alpha_v && !busy && prev_alpha) done_ok++;
    end
    if (inst_in_v && din_pe_v) overlap++;
    prev_alpha = alpha_v;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Host driver: present a word and hold it until accepted; acc = accept cycle
  int acc = 0;

  task automatic put(input logic typ, input logic last, input logic [31:0] d);
    int n;
    s_valid = 1'b1; s_type = typ; s_last = last; s_data = d;
    @(negedge clk);
    n = 1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("put_accept_timeout", 32'(s_ready), 1);
    acc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] ni, input logic [7:0] nt);
    @(posedge clk); #1;
    start = 1'b1; n_inst = ni; n_iter = nt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [4:0] ni;
    logic [7:0] nt;
    bit         stall;
    bit         bad;
    bit         cfg_bad;
    bit         exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    int ib, db, rb, ab, dnb, dob, ob, ni, nt, w, a_bad, inst_acc, data_acc;
    string p;
    p  = $sformatf("v%0d", idx);
    ni = int'(v.ni);
    nt = int'(v.nt);
    ib = inst_q.size(); db = din_q.size(); rb = runs.size();
    ab = alpha_cnt; dnb = done_cnt; dob = done_ok; ob = overlap;
    inst_acc = 0; data_acc = 0;

    do_start(v.ni, v.nt);
    if (v.cfg_bad) begin
      chk({p, "_cfg_err"}, 32'(err), 1);
      chk({p, "_cfg_busy"}, 32'(busy), 0);
      chk({p, "_cfg_ready"}, 32'(s_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      chk({p, "_cfg_busy_later"}, 32'(busy), 0);
      chk({p, "_cfg_ready_later"}, 32'(s_ready), 0);
      return;
    end
    chk({p, "_start_err_clear"}, 32'(err), 0);
    chk({p, "_start_busy"}, 32'(busy), 1);

    for (int i = 0; i < ni; i++) begin
      if (v.bad && i == 1) put(1'b1, 1'b0, 32'hDEAD_BEEF);
      put(1'b0, 1'(i == ni - 1), 32'h11 + 32'(i));
      inst_acc = acc;
      if (i == 0) begin
        // start while busy must be ignored, even with an illegal config
        start = 1'b1; n_inst = 5'd0; n_iter = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end

    for (int b = 0; b < nt; b++) begin
      for (int k = 0; k < 16; k++) begin
        put(1'b1, 1'(v.bad ? (k == 9) : (k == 15)), 32'(b * 256 + k));
        data_acc = acc;
        if (v.stall) begin
          @(posedge clk); #1;
        end
      end
    end

    w = 0;
    while (done_cnt == dnb && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    #1;

    chk({p, "_inst_count"}, 32'(inst_q.size() - ib), 32'(ni));
    if (inst_q.size() - ib == ni) begin
      for (int i = 0; i < ni; i++)
        chk($sformatf("%s_inst%0d", p, i), inst_q[ib + i], 32'h11 + 32'(i));
      chk({p, "_inst_latency"}, 32'(inst_cyc[ib + ni - 1] - inst_acc), 1);
    end

    chk({p, "_din_count"}, 32'(din_q.size() - db), 32'(16 * nt));
    if (din_q.size() - db == 16 * nt) begin
      a_bad = 0;
      for (int j = 0; j < 16 * nt; j++) begin
        chk($sformatf("%s_din%0d", p, j), din_q[db + j], 32'((j / 16) * 256 + (j % 16)));
        if (din_alpha[db + j] != (j >= 16 * (nt - 1))) a_bad++;
      end
      chk({p, "_alpha_per_beat_errors"}, 32'(a_bad), 0);
      chk({p, "_din_latency"}, 32'(din_cyc[db + 16 * (nt - 1)] - data_acc), 2);
      if (nt > 1) chk({p, "_burst_gap_ge16"}, 32'((din_cyc[db + 16] - din_cyc[db + 15] - 1) >= 16), 1);
    end

    chk({p, "_burst_runs"}, 32'(runs.size() - rb), 32'(nt));
    if (runs.size() - rb == nt)
      for (int r = 0; r < nt; r++)
        chk($sformatf("%s_run%0d_len", p, r), 32'(runs[rb + r]), 16);

    chk({p, "_alpha_cycles"}, 32'(alpha_cnt - ab), 32);
    chk({p, "_done_pulses"}, 32'(done_cnt - dnb), 1);
    chk({p, "_done_with_alpha_fall"}, 32'(done_ok - dob), 1);
    chk({p, "_valid_overlap"}, 32'(overlap - ob), 0);
    chk({p, "_err_end"}, 32'(err), 32'(v.exp_err));
    chk({p, "_busy_end"}, 32'(busy), 0);
    chk({p, "_ready_end"}, 32'(s_ready), 0);
  endtask

  initial begin
    int w;
    vecs[0] = '{ni: 5'd3,  nt: 8'd1, stall: 1'b0, bad: 1'b0, cfg_bad: 1'b0, exp_err: 1'b0};
    vecs[1] = '{ni: 5'd3,  nt: 8'd1, stall: 1'b1, bad: 1'b0, cfg_bad: 1'b0, exp_err: 1'b0};
    vecs[2] = '{ni: 5'd2,  nt: 8'd2, stall: 1'b0, bad: 1'b0, cfg_bad: 1'b0, exp_err: 1'b0};
    vecs[3] = '{ni: 5'd3,  nt: 8'd1, stall: 1'b0, bad: 1'b1, cfg_bad: 1'b0, exp_err: 1'b1};
    vecs[4] = '{ni: 5'd1,  nt: 8'd1, stall: 1'b0, bad: 1'b0, cfg_bad: 1'b0, exp_err: 1'b0};
    vecs[5] = '{ni: 5'd0,  nt: 8'd1, stall: 1'b0, bad: 1'b0, cfg_bad: 1'b1, exp_err: 1'b1};
    vecs[6] = '{ni: 5'd17, nt: 8'd1, stall: 1'b0, bad: 1'b0, cfg_bad: 1'b1, exp_err: 1'b1};
    vecs[7] = '{ni: 5'd2,  nt: 8'd0, stall: 1'b0, bad: 1'b0, cfg_bad: 1'b1, exp_err: 1'b1};
    vecs[8] = '{ni: 5'd16, nt: 8'd1, stall: 1'b0, bad: 1'b0, cfg_bad: 1'b0, exp_err: 1'b0};

    #1;
    chk("rst_inst_in_v", 32'(inst_in_v), 0);
    chk("rst_din_pe_v", 32'(din_pe_v), 0);
    chk("rst_alpha_v", 32'(alpha_v), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_din_pe", din_pe, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Asynchronous reset while sending the final burst
    do_start(5'd1, 8'd1);
    put(1'b0, 1'b1, 32'h99);
    for (int k = 0; k < 16; k++) put(1'b1, 1'(k == 15), 32'(k));
    w = 0;
    while (!din_pe_v && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("send_din_pe_v_before_rst", 32'(din_pe_v), 1);
    chk("send_alpha_v_before_rst", 32'(alpha_v), 1);
    chk("send_busy_before_rst", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_din_pe_v", 32'(din_pe_v), 0);
    chk("arst_alpha_v", 32'(alpha_v), 0);
    chk("arst_s_ready", 32'(s_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst_busy", 32'(busy), 0);
    chk("after_rst_din_pe_v", 32'(din_pe_v), 0);
    chk("after_rst_done", 32'(done), 0);
    run_vec(vecs[4], 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
